mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch port and the MEM-stage data port of the pipeline.
- Keeps at most one transaction outstanding on the bus and sequences its address phase and data phase.
- Returns stall indications to the pipeline while a port is waiting.
- Data port normally has priority. A bounded-burst counter stops it from starving fetch. A flush input lets an in-flight fetch finish on the bus while its result is dropped.

Parameters:
- MAX_D_BURST, 4: consecutive data grants allowed while a fetch is pending before fetch is forced.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- i_req  in  1  fetch request; held until i_data_ok.
- i_addr  in  32  fetch address.
- i_data_ok  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  32  fetch data.
- d_req  in  1  data request; held until d_data_ok.
- d_wr  in  1  1 = store.
- d_size  in  2  0 = byte, 1 = half, 2 = word.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_data_ok  out  1  one-cycle pulse; load data valid or store done.
- d_rdata  out  32  load data.
- flush  in  1  exception/eret flush; pending fetch result discarded.
- i_stall  out  1  fetch port waiting.
- d_stall  out  1  data port waiting.
- bus_req  out  1  address-phase request.
- bus_wr  out  1  1 = write.
- bus_size  out  2  transfer size.
- bus_addr  out  32  address.
- bus_wdata  out  32  write data.
- bus_addr_ok  in  1  address accepted this cycle.
- bus_data_ok  in  1  data phase complete this cycle.
- bus_rdata  in  32  read data.

Behaviour:
- Reset is synchronous: the rst sample at a rising edge takes effect on that edge.
- Reset values: state IDLE; bus_req 0; bus_wr 0; bus_size 0; bus_addr 0; bus_wdata 0; i_data_ok 0; d_data_ok 0; i_rdata 0; d_rdata 0; burst counter 0; drop flag 0.
- States: IDLE, ADDR, WAIT. A grant register holds INST or DATA.

IDLE:
- Arbitration:
  - d_req alone -> DATA.
  - i_req alone -> INST.
  - Both -> DATA, unless the burst counter equals MAX_D_BURST, in which case INST.
- On a grant, register the bus_* fields from the winner and go to ADDR. bus_req is 1 in the next cycle, so the request is visible on the bus one cycle after it is sampled.
- Fetch grants drive bus_wr=0, bus_size=2, bus_wdata=0.

ADDR:
- bus_req and all bus_* fields stay stable until bus_addr_ok.
- On bus_addr_ok: bus_req goes 0 next cycle and state moves to WAIT.
- If bus_data_ok arrives in the same cycle as bus_addr_ok, the transaction completes directly; WAIT is skipped.

WAIT:
- On bus_data_ok, return to IDLE.
- Pulse the granted port's *_data_ok one cycle later, with registered *_rdata.
  - Load/fetch: *_rdata = bus_rdata.
  - Store: *_rdata is don't-care.
- Latency with a zero-wait bus (addr_ok in the first ADDR cycle, data_ok the next cycle): request sampled at cycle t -> data_ok pulse at t+3.

Back-to-back:
- While the *_data_ok pulse is high the state is IDLE, so the next grant may be taken in that same cycle.
- A requester that deasserts its req in the pulse cycle is not granted.
- A requester sampled with req still high is treated as a new request.

Burst counter:
- Increments on each DATA grant made while i_req=1, saturating at MAX_D_BURST.
- Clears on any INST grant and whenever i_req=0 in IDLE.

Flush:
- If flush=1 while the grant is INST in ADDR or WAIT, set the drop flag.
  - The bus transaction still completes normally; no abandoning after the address phase.
  - i_data_ok is suppressed for that transaction.
  - The drop flag clears on return to IDLE.
- flush in IDLE, or during a DATA grant, has no effect on the arbiter.

Stalls:
- i_stall = i_req && !i_data_ok. d_stall = d_req && !d_data_ok. Both are combinational.

Misc:
- d_addr alignment is not checked; the MEM stage has already flagged address errors.
- rst in ADDR or WAIT abandons the transaction and returns to IDLE with all outputs at reset values. The bus slave is reset by the same rst.
- Simultaneous bus_addr_ok and bus_data_ok in WAIT are impossible; only bus_data_ok is honoured there.

Test Plan:
- Lone fetch: i_req=1, i_addr=0xBFC00000, zero-wait bus returns 0x3C080001 -> bus_req high for exactly 1 cycle with bus_wr=0, bus_size=2; i_data_ok pulses at t+3 with i_rdata=0x3C080001; i_stall=1 for cycles t..t+2.
- Store: d_req=1, d_wr=1, d_size=0, d_addr=0x80000003, d_wdata=0x000000AB, bus_addr_ok delayed 3 cycles -> bus fields held constant for 4 cycles; d_data_ok pulses once; d_stall deasserts the same cycle.
- Contention, MAX_D_BURST=4, i_req and d_req held high continuously -> grant sequence D,D,D,D,I,D,D,D,D,I; no fetch waits more than 4 data transactions.
- Flush on fetch: fetch of 0x80001000 granted; flush=1 during WAIT -> bus completes, no i_data_ok pulse; the next fetch of 0xBFC00380 returns its own data with one i_data_ok pulse.
- Reset mid-transaction: rst=1 in WAIT -> next cycle bus_req=0, no *_data_ok, state IDLE; a new d_req after reset completes normally.
- Same-cycle addr_ok and data_ok on a load, bus_rdata=0xDEADBEEF -> d_data_ok one cycle later with d_rdata=0xDEADBEEF; no WAIT cycle.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one SRAM-like bus between instruction fetch and
// MEM-stage data accesses, one transaction outstanding, data port priority
// bounded by a burst counter so fetch cannot starve.
module mem_bus_arbiter #(
  parameter int MAX_D_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  input  logic        flush,
  output logic        i_stall,
  output logic        d_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (MAX_D_BURST < 1) ? 1 : $clog2(MAX_D_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_D_BURST);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT} state_t;
  typedef enum logic {G_INST, G_DATA} grant_t;

  state_t        state_q, state_d;
  grant_t        grant_q, grant_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_wr_q, bus_wr_d;
  logic [1:0]    bus_size_q, bus_size_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic          i_data_ok_q, i_data_ok_d;
  logic          d_data_ok_q, d_data_ok_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic [CW-1:0] burst_q, burst_d;
  logic          drop_q, drop_d;
  logic          complete;

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= G_INST;
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_size_q  <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      i_data_ok_q <= 1'b0;
      d_data_ok_q <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      burst_q     <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      bus_req_q   <= bus_req_d;
      bus_wr_q    <= bus_wr_d;
      bus_size_q  <= bus_size_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      i_data_ok_q <= i_data_ok_d;
      d_data_ok_q <= d_data_ok_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      burst_q     <= burst_d;
      drop_q      <= drop_d;
    end
  end

  // Arbitration, bus phase sequencing and completion/drop handling.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    bus_req_d   = bus_req_q;
    bus_wr_d    = bus_wr_q;
    bus_size_d  = bus_size_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    i_data_ok_d = 1'b0;
    d_data_ok_d = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    burst_d     = burst_q;
    drop_d      = drop_q;
    complete    = 1'b0;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (!i_req) burst_d = '0;
        if (d_req && !(i_req && burst_q == BURST_MAX)) begin
          grant_d     = G_DATA;
          state_d     = S_ADDR;
          bus_req_d   = 1'b1;
          bus_wr_d    = d_wr;
          bus_size_d  = d_size;
          bus_addr_d  = d_addr;
          bus_wdata_d = d_wdata;
          // Reaching here with i_req set implies burst_q is below the cap.
          if (i_req) burst_d = burst_q + CW'(1);
        end else if (i_req) begin
          grant_d     = G_INST;
          state_d     = S_ADDR;
          bus_req_d   = 1'b1;
          bus_wr_d    = 1'b0;
          bus_size_d  = 2'd2;
          bus_addr_d  = i_addr;
          bus_wdata_d = '0;
          burst_d     = '0;
        end
      end
      S_ADDR: begin
        if (flush && grant_q == G_INST) drop_d = 1'b1;
        if (bus_addr_ok) begin
          bus_req_d = 1'b0;
          if (bus_data_ok) complete = 1'b1;
          else state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush && grant_q == G_INST) drop_d = 1'b1;
        if (bus_data_ok) complete = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      state_d = S_IDLE;
      drop_d  = 1'b0;
      if (grant_q == G_DATA) begin
        d_data_ok_d = 1'b1;
        d_rdata_d   = bus_rdata;
      end else if (!(drop_q || flush)) begin
        // A flush arriving in the completing cycle still drops the result.
        i_data_ok_d = 1'b1;
        i_rdata_d   = bus_rdata;
      end
    end
  end

  assign i_data_ok = i_data_ok_q;
  assign d_data_ok = d_data_ok_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_wr    = bus_wr_q;
  assign bus_size  = bus_size_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign i_stall   = i_req && !i_data_ok_q;
  assign d_stall   = d_req && !d_data_ok_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: scripted bus slave plus per-scenario tasks
// checking completions against a scoreboard of expected responses.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr, flush;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        i_data_ok, d_data_ok, i_stall, d_stall;
  logic [31:0] i_rdata, d_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
    logic        chk;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Slave configuration
  int          addr_lat   = 0;
  int          data_lat   = 0;
  logic        same_cycle = 1'b0;
  logic        fixed_en   = 1'b0;
  logic [31:0] fixed_rdata = '0;

  mem_bus_arbiter #(.MAX_D_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .flush(flush), .i_stall(i_stall), .d_stall(d_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] resp(input logic [31:0] a);
    return fixed_en ? fixed_rdata : {a[15:0], ~a[31:16]};
  endfunction

  // Bus slave: outputs change 1 time unit after each rising edge.
  initial begin
    int cnt = 0;
    int dcnt = 0;
    logic pend = 1'b0;
    logic [31:0] lat_addr = '0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (rst) begin
        pend = 1'b0;
        cnt  = 0;
      end else if (pend) begin
        if (dcnt == data_lat) begin
          bus_data_ok = 1'b1;
          bus_rdata   = resp(lat_addr);
          pend        = 1'b0;
        end else dcnt++;
      end else if (bus_req) begin
        if (cnt == addr_lat) begin
          bus_addr_ok = 1'b1;
          cnt         = 0;
          lat_addr    = bus_addr;
          if (same_cycle) begin
            bus_data_ok = 1'b1;
            bus_rdata   = resp(bus_addr);
          end else begin
            pend = 1'b1;
            dcnt = 0;
          end
        end else cnt++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0; flush = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_size = '0;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({bus_req, bus_wr, bus_size, bus_addr, bus_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got req=%b wr=%b size=%0d addr=%h wdata=%h, required all 0",
               bus_req, bus_wr, bus_size, bus_addr, bus_wdata);
    end
    n_assert++;
    if ({i_data_ok, d_data_ok, i_rdata, d_rdata, i_stall, d_stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_ports: got iok=%b dok=%b ird=%h drd=%h istall=%b dstall=%b, required all 0",
               i_data_ok, d_data_ok, i_rdata, d_rdata, i_stall, d_stall);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lone_fetch();
    int bus_cycles = 0;
    int pulse_at = -1;
    exp_t e;
    fixed_en = 1; fixed_rdata = 32'h3C08_0001; addr_lat = 0; data_lat = 0; same_cycle = 0;
    i_req = 1; i_addr = 32'hBFC0_0000;
    sb.push_back(exp_t'{1'b0, 32'h3C08_0001, 1'b1});
    #1;
    n_assert++;
    if (i_stall !== 1'b1) begin n_fail++; $display("FAIL lone_stall_t: got %b required 1", i_stall); end
    for (int k = 1; k <= 10 && pulse_at < 0; k++) begin
      @(negedge clk);
      if (bus_req === 1'b1) begin
        bus_cycles++;
        n_assert++;
        if (bus_wr !== 1'b0 || bus_size !== 2'd2 || bus_addr !== 32'hBFC0_0000 || bus_wdata !== '0) begin
          n_fail++;
          $display("FAIL lone_bus_fields: got wr=%b size=%0d addr=%h wdata=%h required 0/2/bfc00000/0",
                   bus_wr, bus_size, bus_addr, bus_wdata);
        end
      end
      if (k < 3) begin
        n_assert++;
        if (i_stall !== 1'b1) begin n_fail++; $display("FAIL lone_stall_c%0d: got %b required 1", k, i_stall); end
      end
      if (d_data_ok === 1'b1) begin n_assert++; n_fail++; $display("FAIL lone_spurious_d: got d_data_ok=1 required 0"); end
      if (i_data_ok === 1'b1) begin
        pulse_at = k;
        n_assert++;
        if (i_stall !== 1'b0) begin n_fail++; $display("FAIL lone_stall_pulse: got %b required 0", i_stall); end
        n_assert++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL lone_sb: got pulse, required scoreboard entry"); end
        else begin
          e = sb.pop_front();
          if (e.is_data !== 1'b0 || i_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL lone_rdata: got I/%h required %s/%h", i_rdata, e.is_data ? "D" : "I", e.rdata);
          end
        end
        i_req = 0;
      end
    end
    n_assert++;
    if (pulse_at != 3) begin n_fail++; $display("FAIL lone_latency: got %0d required 3", pulse_at); end
    n_assert++;
    if (bus_cycles != 1) begin n_fail++; $display("FAIL lone_req_cycles: got %0d required 1", bus_cycles); end
    @(negedge clk);
  endtask

  task automatic test_store();
    int bus_cycles = 0;
    int pulse_at = -1;
    int pulses = 0;
    exp_t e;
    fixed_en = 0; addr_lat = 3; data_lat = 0; same_cycle = 0;
    d_req = 1; d_wr = 1; d_size = 2'd0; d_addr = 32'h8000_0003; d_wdata = 32'h0000_00AB;
    sb.push_back(exp_t'{1'b1, 32'h0, 1'b0});
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus_req === 1'b1) begin
        bus_cycles++;
        n_assert++;
        if (bus_wr !== 1'b1 || bus_size !== 2'd0 || bus_addr !== 32'h8000_0003 || bus_wdata !== 32'hAB) begin
          n_fail++;
          $display("FAIL store_bus_fields: got wr=%b size=%0d addr=%h wdata=%h required 1/0/80000003/000000ab",
                   bus_wr, bus_size, bus_addr, bus_wdata);
        end
      end
      if (d_data_ok === 1'b1) begin
        pulses++;
        pulse_at = k;
        n_assert++;
        if (d_stall !== 1'b0) begin n_fail++; $display("FAIL store_stall_pulse: got %b required 0", d_stall); end
        n_assert++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL store_sb: got pulse, required scoreboard entry"); end
        else begin
          e = sb.pop_front();
          if (e.is_data !== 1'b1) begin n_fail++; $display("FAIL store_port: got D required I"); end
        end
        d_req = 0;
      end
    end
    n_assert++;
    if (bus_cycles != 4) begin n_fail++; $display("FAIL store_req_cycles: got %0d required 4", bus_cycles); end
    n_assert++;
    if (pulses != 1 || pulse_at != 6) begin
      n_fail++;
      $display("FAIL store_pulse: got %0d pulses at cycle %0d required 1 at cycle 6", pulses, pulse_at);
    end
    d_wr = 0;
  endtask

  task automatic test_contention();
    int got = 0;
    exp_t e;
    logic seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    fixed_en = 0; addr_lat = 0; data_lat = 0; same_cycle = 0;
    i_addr = 32'hBFC0_0010; d_addr = 32'h8000_2000; d_wr = 0; d_size = 2'd2;
    for (int n = 0; n < 10; n++)
      sb.push_back(exp_t'{seq[n], resp(seq[n] ? 32'h8000_2000 : 32'hBFC0_0010), 1'b1});
    i_req = 1; d_req = 1;
    for (int k = 0; k < 200 && got < 10; k++) begin
      @(negedge clk);
      if (i_data_ok === 1'b1 || d_data_ok === 1'b1) begin
        n_assert++;
        if (sb.size() == 0 || (i_data_ok === 1'b1 && d_data_ok === 1'b1)) begin
          n_fail++;
          $display("FAIL cont_pulse%0d: got iok=%b dok=%b sb=%0d required one pulse and an entry",
                   got, i_data_ok, d_data_ok, sb.size());
        end else begin
          e = sb.pop_front();
          if (d_data_ok !== e.is_data || (e.is_data ? d_rdata : i_rdata) !== e.rdata) begin
            n_fail++;
            $display("FAIL cont_grant%0d: got %s/%h required %s/%h", got, d_data_ok ? "D" : "I",
                     d_data_ok ? d_rdata : i_rdata, e.is_data ? "D" : "I", e.rdata);
          end
        end
        got++;
        if (got == 10) begin i_req = 0; d_req = 0; end
      end
    end
    n_assert++;
    if (got != 10) begin n_fail++; $display("FAIL cont_timeout: got %0d completions required 10", got); i_req = 0; d_req = 0; end
    @(negedge clk);
  endtask

  task automatic test_flush();
    int pulses = 0;
    int dataoks = 0;
    int seen = 0;
    exp_t e;
    fixed_en = 0; addr_lat = 0; data_lat = 2; same_cycle = 0;
    i_req = 1; i_addr = 32'h8000_1000;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clk);
      if (bus_req === 1'b1) seen = 1;
    end
    @(negedge clk);
    n_assert++;
    if (seen == 0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL flush_wait_state: got seen=%0d bus_req=%b required 1/0", seen, bus_req); end
    flush = 1; i_addr = 32'hBFC0_0380;
    sb.push_back(exp_t'{1'b0, resp(32'hBFC0_0380), 1'b1});
    @(negedge clk);
    flush = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_data_ok === 1'b1) dataoks++;
      if (i_data_ok === 1'b1) begin
        pulses++;
        n_assert++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL flush_sb: got extra pulse rdata=%h required none", i_rdata); end
        else begin
          e = sb.pop_front();
          if (e.is_data !== 1'b0 || i_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL flush_rdata: got %h required %h", i_rdata, e.rdata);
          end
        end
        i_req = 0;
      end
    end
    n_assert++;
    if (pulses != 1) begin n_fail++; $display("FAIL flush_pulses: got %0d required 1", pulses); end
    n_assert++;
    if (dataoks != 2) begin n_fail++; $display("FAIL flush_bus_done: got %0d bus completions required 2", dataoks); end
    i_req = 0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int pulse_at = -1;
    exp_t e;
    fixed_en = 0; addr_lat = 0; data_lat = 3; same_cycle = 0;
    d_req = 1; d_wr = 0; d_size = 2'd2; d_addr = 32'h8000_0100;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clk);
      if (bus_req === 1'b1) seen = 1;
    end
    @(negedge clk);
    rst = 1; d_req = 0;
    @(negedge clk);
    n_assert++;
    if (seen == 0 || bus_req !== 1'b0 || bus_addr !== '0 || d_data_ok !== 1'b0 || i_data_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got req=%b addr=%h dok=%b iok=%b required 0/0/0/0",
               bus_req, bus_addr, d_data_ok, i_data_ok);
    end
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_assert++;
      if (bus_req !== 1'b0 || d_data_ok !== 1'b0 || i_data_ok !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_idle%0d: got req=%b dok=%b iok=%b required 0", k, bus_req, d_data_ok, i_data_ok);
      end
    end
    data_lat = 0;
    d_req = 1; d_addr = 32'h8000_0200;
    sb.push_back(exp_t'{1'b1, resp(32'h8000_0200), 1'b1});
    for (int k = 1; k <= 10 && pulse_at < 0; k++) begin
      @(negedge clk);
      if (d_data_ok === 1'b1) begin
        pulse_at = k;
        n_assert++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rstmid_sb: got pulse, required scoreboard entry"); end
        else begin
          e = sb.pop_front();
          if (e.is_data !== 1'b1 || d_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL rstmid_rdata: got %h required %h", d_rdata, e.rdata);
          end
        end
        d_req = 0;
      end
    end
    n_assert++;
    if (pulse_at != 3) begin n_fail++; $display("FAIL rstmid_latency: got %0d required 3", pulse_at); d_req = 0; end
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    int bus_cycles = 0;
    int pulse_at = -1;
    exp_t e;
    fixed_en = 1; fixed_rdata = 32'hDEAD_BEEF; addr_lat = 0; data_lat = 0; same_cycle = 1;
    d_req = 1; d_wr = 0; d_size = 2'd2; d_addr = 32'h8000_0400;
    sb.push_back(exp_t'{1'b1, 32'hDEAD_BEEF, 1'b1});
    for (int k = 1; k <= 10 && pulse_at < 0; k++) begin
      @(negedge clk);
      if (bus_req === 1'b1) bus_cycles++;
      if (d_data_ok === 1'b1) begin
        pulse_at = k;
        n_assert++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL same_sb: got pulse, required scoreboard entry"); end
        else begin
          e = sb.pop_front();
          if (e.is_data !== 1'b1 || d_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL same_rdata: got %h required %h", d_rdata, e.rdata);
          end
        end
        d_req = 0;
      end
    end
    n_assert++;
    if (pulse_at != 2 || bus_cycles != 1) begin
      n_fail++;
      $display("FAIL same_latency: got pulse at %0d, req cycles %0d required 2 and 1", pulse_at, bus_cycles);
    end
    d_req = 0; same_cycle = 0; fixed_en = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_store();
    test_contention();
    test_flush();
    test_reset_mid();
    test_same_cycle();
    n_assert++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drained: got %0d entries left required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
